video_scale_near_param: RTL and testbench

//  Parametrised nearest-neighbour video downscaler with full valid/ready flow control.

---
 rtl/video_scale_near_param.sv | 228 ++++++++++++++++++++++
 tb/tb_video_scale_near_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scale_near_param.sv
// Nearest-neighbour video downscaler: a sequential divider derives Q(FRAC) step factors for each frame,
// then input pixels whose coordinates hit the step accumulators are forwarded with sof/eol markers.
module video_scale_near_param #(
  parameter int DW    = 24,
  parameter int RES_W = 16,
  parameter int FRAC  = 16
) (
  input  logic             vin_clk,
  input  logic             rst_n,
  input  logic             frame_vs,
  input  logic [RES_W-1:0] vin_xres,
  input  logic [RES_W-1:0] vin_yres,
  input  logic [RES_W-1:0] vout_xres,
  input  logic [RES_W-1:0] vout_yres,
  input  logic [DW-1:0]    vin_dat,
  input  logic             vin_valid,
  output logic             vin_ready,
  output logic [DW-1:0]    vout_dat,
  output logic             vout_valid,
  input  logic             vout_ready,
  output logic             vout_sof,
  output logic             vout_eol,
  output logic             cfg_err,
  output logic             busy
);

  localparam int AW = RES_W + FRAC;
  localparam int CW = $clog2(AW);
  localparam logic [CW-1:0] LAST_BIT = CW'(AW - 1);

  typedef enum logic [2:0] {IDLE, CALC, RUN, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic             vs_q, vs_d;
  logic [RES_W-1:0] xin_q, xin_d, yin_q, yin_d, xout_q, xout_d, yout_q, yout_d;
  logic [AW-1:0]    qx_q, qx_d, qy_q, qy_d, rx_q, rx_d, ry_q, ry_d;
  logic [AW-1:0]    step_x_q, step_x_d, step_y_q, step_y_d;
  logic [AW-1:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0] vin_x_q, vin_x_d, vin_y_q, vin_y_d, ox_q, ox_d;
  logic             first_q, first_d;
  logic [DW-1:0]    vout_dat_q, vout_dat_d;
  logic             vout_valid_q, vout_valid_d, vout_sof_q, vout_sof_d, vout_eol_q, vout_eol_d;

  logic          vs_rise, beat, row_kept, kept, line_end, frame_end, cfg_bad;
  logic [AW-1:0] rx_n, qx_n, ry_n, qy_n;

  // One restoring-division step: the quotient register doubles as the dividend shifter.
  function automatic logic [2*AW-1:0] div_step(input logic [AW-1:0] rem,
                                                input logic [AW-1:0] quo,
                                                input logic [RES_W-1:0] dvs);
    logic [AW-1:0] sh;
    logic [AW-1:0] d;
    sh = {rem[AW-2:0], quo[AW-1]};
    d  = AW'(dvs);
    if (sh >= d) return {sh - d, quo[AW-2:0], 1'b1};
    else         return {sh, quo[AW-2:0], 1'b0};
  endfunction

  assign {rx_n, qx_n} = div_step(rx_q, qx_q, xout_q);
  assign {ry_n, qy_n} = div_step(ry_q, qy_q, yout_q);

  assign vs_rise   = frame_vs & ~vs_q;
  assign vin_ready = (state_q == RUN) ? (~vout_valid_q | vout_ready)
                                      : ((state_q == DONE) || (state_q == ERR));
  assign beat      = vin_valid & vin_ready;
  assign row_kept  = (acc_y_q[FRAC +: RES_W] == vin_y_q);
  assign kept      = row_kept && (acc_x_q[FRAC +: RES_W] == vin_x_q);
  assign line_end  = (vin_x_q == xin_q - RES_W'(1));
  assign frame_end = line_end && (vin_y_q == yin_q - RES_W'(1));
  assign cfg_bad   = (vout_xres == '0) || (vout_yres == '0) ||
                     (vout_xres > vin_xres) || (vout_yres > vin_yres);

  assign vout_dat   = vout_dat_q;
  assign vout_valid = vout_valid_q;
  assign vout_sof   = vout_sof_q;
  assign vout_eol   = vout_eol_q;
  assign cfg_err    = (state_q == ERR);
  assign busy       = (state_q == CALC) || (state_q == RUN);

  always_comb begin
    state_d      = state_q;
    vs_d         = frame_vs;
    xin_d        = xin_q;
    yin_d        = yin_q;
    xout_d       = xout_q;
    yout_d       = yout_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    step_x_d     = step_x_q;
    step_y_d     = step_y_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    cnt_d        = cnt_q;
    vin_x_d      = vin_x_q;
    vin_y_d      = vin_y_q;
    ox_d         = ox_q;
    first_d      = first_q;
    vout_dat_d   = vout_dat_q;
    vout_valid_d = vout_valid_q;
    vout_sof_d   = vout_sof_q;
    vout_eol_d   = vout_eol_q;

    // An accepted output retires; a stalled one holds everything.
    if (vout_ready) begin
      vout_valid_d = 1'b0;
      vout_sof_d   = 1'b0;
      vout_eol_d   = 1'b0;
    end

    case (state_q)
      CALC: begin
        qx_d  = qx_n;
        rx_d  = rx_n;
        qy_d  = qy_n;
        ry_d  = ry_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          step_x_d = qx_n;
          step_y_d = qy_n;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (beat) begin
          if (kept) begin
            vout_dat_d   = vin_dat;
            vout_valid_d = 1'b1;
            vout_sof_d   = first_q;
            vout_eol_d   = (ox_q == xout_q - RES_W'(1));
            first_d      = 1'b0;
            ox_d         = ox_q + RES_W'(1);
            acc_x_d      = acc_x_q + step_x_q;
          end
          if (line_end) begin
            vin_x_d = '0;
            acc_x_d = '0;
            ox_d    = '0;
            vin_y_d = vin_y_q + RES_W'(1);
            if (row_kept) acc_y_d = acc_y_q + step_y_q;
            if (frame_end) state_d = DONE;
          end else begin
            vin_x_d = vin_x_q + RES_W'(1);
          end
        end
      end
      default: ;
    endcase

    // A new frame overrides whatever the current state was doing, including a held output.
    if (vs_rise) begin
      xin_d        = vin_xres;
      yin_d        = vin_yres;
      xout_d       = vout_xres;
      yout_d       = vout_yres;
      qx_d         = {vin_xres, FRAC'(0)};
      qy_d         = {vin_yres, FRAC'(0)};
      rx_d         = '0;
      ry_d         = '0;
      cnt_d        = '0;
      acc_x_d      = '0;
      acc_y_d      = '0;
      vin_x_d      = '0;
      vin_y_d      = '0;
      ox_d         = '0;
      first_d      = 1'b1;
      vout_valid_d = 1'b0;
      vout_sof_d   = 1'b0;
      vout_eol_d   = 1'b0;
      state_d      = cfg_bad ? ERR : CALC;
    end
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      xin_q        <= '0;
      yin_q        <= '0;
      xout_q       <= '0;
      yout_q       <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      step_x_q     <= '0;
      step_y_q     <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      cnt_q        <= '0;
      vin_x_q      <= '0;
      vin_y_q      <= '0;
      ox_q         <= '0;
      first_q      <= 1'b0;
      vout_dat_q   <= '0;
      vout_valid_q <= 1'b0;
      vout_sof_q   <= 1'b0;
      vout_eol_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      xin_q        <= xin_d;
      yin_q        <= yin_d;
      xout_q       <= xout_d;
      yout_q       <= yout_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      step_x_q     <= step_x_d;
      step_y_q     <= step_y_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      cnt_q        <= cnt_d;
      vin_x_q      <= vin_x_d;
      vin_y_q      <= vin_y_d;
      ox_q         <= ox_d;
      first_q      <= first_d;
      vout_dat_q   <= vout_dat_d;
      vout_valid_q <= vout_valid_d;
      vout_sof_q   <= vout_sof_d;
      vout_eol_q   <= vout_eol_d;
    end
  end

endmodule

// File: tb/tb_video_scale_near_param.sv
// Self-checking bench for video_scale_near_param: an arithmetic frame model feeds an expected-output
// queue that a negedge monitor drains on every handshake, plus literal pixel tables for key cases.
module tb_video_scale_near_param;

  localparam int DW    = 24;
  localparam int RES_W = 16;
  localparam int FRAC  = 16;

  logic             vin_clk = 1'b0;
  logic             rst_n;
  logic             frame_vs;
  logic [RES_W-1:0] vin_xres, vin_yres, vout_xres, vout_yres;
  logic [DW-1:0]    vin_dat;
  logic             vin_valid;
  logic             vin_ready;
  logic [DW-1:0]    vout_dat;
  logic             vout_valid;
  logic             vout_ready;
  logic             vout_sof, vout_eol, cfg_err, busy;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [25:0] exp_q[$];
  logic [23:0] out_log[$];
  int          out_count   = 0;
  int          rdy_mode    = 0;
  bit          chk_stable  = 0;

  logic [23:0] t1_exp [8] = '{24'h000000, 24'h000002, 24'h000004, 24'h000006,
                              24'h002000, 24'h002002, 24'h002004, 24'h002006};
  int          t2_cols [8] = '{0, 1, 3, 4, 6, 7, 9, 10};

  always #5 vin_clk = ~vin_clk;

  video_scale_near_param #(.DW(DW), .RES_W(RES_W), .FRAC(FRAC)) dut (
    .vin_clk(vin_clk), .rst_n(rst_n), .frame_vs(frame_vs),
    .vin_xres(vin_xres), .vin_yres(vin_yres), .vout_xres(vout_xres), .vout_yres(vout_yres),
    .vin_dat(vin_dat), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vout_dat(vout_dat), .vout_valid(vout_valid), .vout_ready(vout_ready),
    .vout_sof(vout_sof), .vout_eol(vout_eol), .cfg_err(cfg_err), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    return {y[11:0], x[11:0]};
  endfunction

  // Expected frame: the k-th output column sits at floor(k*step), step = floor(in*2^FRAC/out).
  task automatic pushModel(input int xi, input int yi, input int xo, input int yo);
    longint sx, sy;
    int px, py;
    sx = (longint'(xi) << FRAC) / xo;
    sy = (longint'(yi) << FRAC) / yo;
    for (int j = 0; j < yo; j++)
      for (int i = 0; i < xo; i++) begin
        px = int'((longint'(i) * sx) >> FRAC);
        py = int'((longint'(j) * sy) >> FRAC);
        exp_q.push_back({pix(px, py), (i == 0 && j == 0), (i == xo - 1)});
      end
  endtask

  // Pulses frame_vs and waits (bounded) until the scaler accepts input.
  task automatic startFrame(input int xi, input int yi, input int xo, input int yo,
                            output int zeros, output logic v_after, output logic b_after);
    vin_xres  = RES_W'(xi);
    vin_yres  = RES_W'(yi);
    vout_xres = RES_W'(xo);
    vout_yres = RES_W'(yo);
    frame_vs  = 1'b1;
    @(posedge vin_clk); #1;
    frame_vs = 1'b0;
    v_after  = vout_valid;
    b_after  = busy;
    zeros    = 0;
    while (!vin_ready && zeros < 100) begin
      zeros++;
      @(posedge vin_clk); #1;
    end
  endtask

  // Drives pixels in raster order; limit < 0 feeds the whole frame.
  task automatic applyStimulus(input int xi, input int yi, input int limit);
    int x = 0, y = 0, n = 0, guard = 0;
    logic r;
    while (y < yi && (limit < 0 || n < limit)) begin
      vin_valid = 1'b1;
      vin_dat   = pix(x, y);
      @(negedge vin_clk);
      r = vin_ready;
      @(posedge vin_clk); #1;
      if (r) begin
        n++;
        x++;
        if (x == xi) begin
          x = 0;
          y++;
        end
      end
      guard++;
      if (guard > 20000) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL feed_timeout: got %0d beats, expected %0d", n, xi * yi);
        break;
      end
    end
    vin_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || vout_valid) && n < 500) begin
      @(posedge vin_clk); #1;
      n++;
    end
    checkOutput("drain_left", exp_q.size(), 0);
  endtask

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    forever begin
      @(posedge vin_clk); #1;
      case (rdy_mode)
        1:       vout_ready = 1'($urandom_range(0, 1));
        2:       vout_ready = 1'b0;
        default: vout_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: every handshake must match the head of the model queue.
  initial begin
    bit          prev_stall = 0;
    logic [25:0] held = '0;
    logic [25:0] e;
    forever begin
      @(negedge vin_clk);
      if (chk_stable && prev_stall)
        checkOutput("stall_hold", {vout_valid, vout_dat, vout_sof, vout_eol}, {1'b1, held});
      prev_stall = rst_n && vout_valid && !vout_ready;
      held       = {vout_dat, vout_sof, vout_eol};
      if (rst_n && vout_valid && vout_ready) begin
        out_count++;
        out_log.push_back(vout_dat);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_output: got dat=0x%0h sof=%0b eol=%0b, expected none",
                   vout_dat, vout_sof, vout_eol);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pixel", {vout_dat, vout_sof, vout_eol}, e);
        end
      end
    end
  end

  initial begin
    int   zeros, base;
    logic va, ba;

    rst_n = 1'b0; frame_vs = 1'b0; vin_valid = 1'b0; vin_dat = '0; vout_ready = 1'b1;
    vin_xres = '0; vin_yres = '0; vout_xres = '0; vout_yres = '0;
    @(posedge vin_clk); @(posedge vin_clk); #1;
    checkOutput("rst_outputs", {vin_ready, vout_valid, vout_sof, vout_eol, cfg_err, busy}, 0);
    checkOutput("rst_dat", vout_dat, 0);
    rst_n = 1'b1;
    @(posedge vin_clk); #1;
    checkOutput("idle_ready", vin_ready, 0);

    // 8x4 -> 4x2, always ready
    out_log.delete(); out_count = 0;
    pushModel(8, 4, 4, 2);
    startFrame(8, 4, 4, 2, zeros, va, ba);
    checkOutput("calc_cycles", zeros, 32);
    checkOutput("calc_busy", ba, 1);
    applyStimulus(8, 4, -1);
    drain();
    checkOutput("t1_count", out_count, 8);
    if (out_log.size() == 8)
      for (int k = 0; k < 8; k++) checkOutput($sformatf("t1_pix%0d", k), out_log[k], t1_exp[k]);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_ready", vin_ready, 1);

    // 12x6 -> 8x4, step 1.5: kept columns/rows 0,1,3,4,...
    out_log.delete(); out_count = 0;
    pushModel(12, 6, 8, 4);
    startFrame(12, 6, 8, 4, zeros, va, ba);
    applyStimulus(12, 6, -1);
    drain();
    checkOutput("t2_count", out_count, 32);
    if (out_log.size() == 32) begin
      for (int k = 0; k < 8; k++) checkOutput($sformatf("t2_col%0d", k), out_log[k], 24'(t2_cols[k]));
      checkOutput("t2_row1", out_log[8], 24'h001000);
      checkOutput("t2_last", out_log[31], 24'h00400A);
    end

    // Case 1 again under random backpressure
    out_log.delete(); out_count = 0;
    rdy_mode = 1; chk_stable = 1;
    pushModel(8, 4, 4, 2);
    startFrame(8, 4, 4, 2, zeros, va, ba);
    applyStimulus(8, 4, -1);
    drain();
    chk_stable = 0; rdy_mode = 0;
    checkOutput("t3_count", out_count, 8);
    if (out_log.size() == 8)
      for (int k = 0; k < 8; k++) checkOutput($sformatf("t3_pix%0d", k), out_log[k], t1_exp[k]);

    // Upscale request is illegal
    startFrame(640, 480, 1024, 768, zeros, va, ba);
    checkOutput("err_flag", cfg_err, 1);
    checkOutput("err_ready", vin_ready, 1);
    checkOutput("err_busy", ba, 0);
    base = out_count;
    applyStimulus(640, 480, 20);
    checkOutput("err_outputs", out_count - base, 0);
    checkOutput("err_flag_hold", cfg_err, 1);
    out_log.delete(); out_count = 0;
    pushModel(8, 4, 4, 2);
    startFrame(8, 4, 4, 2, zeros, va, ba);
    checkOutput("err_cleared", cfg_err, 0);
    applyStimulus(8, 4, -1);
    drain();
    checkOutput("t4_count", out_count, 8);

    // Abort mid-line while an output is held
    rdy_mode = 2;
    @(posedge vin_clk); #1;
    startFrame(8, 4, 4, 2, zeros, va, ba);
    applyStimulus(8, 4, 1);
    repeat (3) @(posedge vin_clk);
    #1;
    checkOutput("abort_held_valid", vout_valid, 1);
    checkOutput("abort_held_sof", vout_sof, 1);
    exp_q.delete(); out_log.delete(); out_count = 0;
    pushModel(8, 4, 4, 2);
    startFrame(8, 4, 4, 2, zeros, va, ba);
    checkOutput("abort_valid_drop", va, 0);
    rdy_mode = 0;
    applyStimulus(8, 4, -1);
    drain();
    checkOutput("t5_count", out_count, 8);
    if (out_log.size() > 0) checkOutput("t5_first", out_log[0], 24'h000000);

    // Equal resolution passes every pixel through
    out_log.delete(); out_count = 0;
    pushModel(16, 4, 16, 4);
    startFrame(16, 4, 16, 4, zeros, va, ba);
    applyStimulus(16, 4, -1);
    drain();
    checkOutput("t6_count", out_count, 64);
    if (out_log.size() == 64) begin
      checkOutput("t6_eol_pix", out_log[15], 24'h00000F);
      checkOutput("t6_last", out_log[63], 24'h00300F);
    end

    // Asynchronous reset in the middle of a frame
    pushModel(16, 4, 16, 4);
    startFrame(16, 4, 16, 4, zeros, va, ba);
    applyStimulus(16, 4, 20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_outputs", {vin_ready, vout_valid, vout_sof, vout_eol, cfg_err, busy}, 0);
    checkOutput("mid_rst_dat", vout_dat, 0);
    exp_q.delete();
    @(posedge vin_clk); #1;
    rst_n = 1'b1;
    @(posedge vin_clk); #1;
    checkOutput("post_rst_ready", vin_ready, 0);
    out_log.delete(); out_count = 0;
    pushModel(8, 4, 4, 2);
    startFrame(8, 4, 4, 2, zeros, va, ba);
    applyStimulus(8, 4, -1);
    drain();
    checkOutput("t7_count", out_count, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
